// File: rtl/sd_sched_pkg.sv
// Shared encodings and slice geometry for the display scheduler.
// Pure definitions: no latency, no flow control.
package sd_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int NUM_SRC   = 3;
   localparam int SRC_TIME  = 0;
   localparam int SRC_ALARM = 1;
   localparam int SRC_SET   = 2;

   localparam int DIG_W  = 4;
   localparam int NUM_W  = 6 * DIG_W;
   localparam int MASK_W = 6;

   localparam logic [MASK_W-1:0] BLANK_TWK = 6'b111111;

endpackage

// File: rtl/sd_sched_if.sv
// Source inputs and sd_itf-facing outputs of the scheduler.
// master drives the sources; slave is the scheduler itself.
interface sd_sched_if;
   import sd_sched_pkg::*;

   logic [NUM_SRC-1:0]        src_req;
   logic [NUM_SRC*NUM_W-1:0]  src_num;
   logic [NUM_SRC*MASK_W-1:0] src_dp;
   logic [NUM_SRC*MASK_W-1:0] src_twk;

   logic [NUM_SRC-1:0] grant;
   logic               busy;
   logic               valid_sd;
   logic [MASK_W-1:0]  twinkle;
   logic [MASK_W-1:0]  dp;
   logic [DIG_W-1:0]   num6, num5, num4, num3, num2, num1;

   modport master (
      output src_req, src_num, src_dp, src_twk,
      input  grant, busy, valid_sd, twinkle, dp, num6, num5, num4, num3, num2, num1
   );

   modport slave (
      input  src_req, src_num, src_dp, src_twk,
      output grant, busy, valid_sd, twinkle, dp, num6, num5, num4, num3, num2, num1
   );

endinterface

// File: rtl/sd_prio_arb.sv
// Fixed-priority one-hot arbiter: setting > alarm > time.
// Combinational, zero latency; no backpressure.
module sd_prio_arb
   import sd_sched_pkg::*;
(
   input  logic [NUM_SRC-1:0] req_i,
   output logic [NUM_SRC-1:0] gnt_o
);

   always_comb begin
      gnt_o = '0;
      if (req_i[SRC_SET])        gnt_o[SRC_SET]   = 1'b1;
      else if (req_i[SRC_ALARM]) gnt_o[SRC_ALARM] = 1'b1;
      else if (req_i[SRC_TIME])  gnt_o[SRC_TIME]  = 1'b1;
   end

endmodule

// File: rtl/sd_sched.sv
// Picks a display source and latches its frame for sd_itf; valid_sd 2 cycles after a trigger.
// No backpressure: after each pulse the block holds SHIFT_CYC cycles, deferring ticks as pending.
module sd_sched
   import sd_sched_pkg::*;
#(
   parameter int REFRESH_CYC = 50000,
   parameter int SHIFT_CYC   = 64,
   parameter int BLINK_CYC   = 25000000
) (
   input  logic   sysclk,
   input  logic   rst,
   sd_sched_if.slave bus
);

   localparam int RW = $clog2(REFRESH_CYC);
   localparam int HW = $clog2(SHIFT_CYC);
   localparam int BW = $clog2(BLINK_CYC);
   localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(SHIFT_CYC - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

   state_e              state_q, state_d;
   logic [RW-1:0]       ref_cnt_q;
   logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
   logic [BW-1:0]       blink_cnt_q;
   logic                blink_off_q;
   logic                pending_q, pending_d;
   logic                load;
   logic                tick;
   logic [NUM_SRC-1:0]  arb;
   logic [NUM_SRC-1:0]  grant_q;
   logic                valid_q;
   logic [NUM_W-1:0]    num_q, sel_num;
   logic [MASK_W-1:0]   dp_q, sel_dp;
   logic [MASK_W-1:0]   twk_q, sel_twk;

   sd_prio_arb u_arb (
      .req_i (bus.src_req),
      .gnt_o (arb)
   );

   assign tick = (ref_cnt_q == REF_LAST);

   always_ff @(posedge sysclk) begin
      if (rst) begin
         ref_cnt_q   <= '0;
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
      end else begin
         ref_cnt_q <= tick ? '0 : ref_cnt_q + RW'(1);
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_off_q <= ~blink_off_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
         end
      end
   end

   // No source granted means a blank frame: everything dark.
   always_comb begin
      sel_num = '0;
      sel_dp  = '0;
      sel_twk = BLANK_TWK;
      case (arb)
         3'b001: begin
            sel_num = bus.src_num[SRC_TIME*NUM_W +: NUM_W];
            sel_dp  = bus.src_dp[SRC_TIME*MASK_W +: MASK_W];
            sel_twk = bus.src_twk[SRC_TIME*MASK_W +: MASK_W] & {MASK_W{blink_off_q}};
         end
         3'b010: begin
            sel_num = bus.src_num[SRC_ALARM*NUM_W +: NUM_W];
            sel_dp  = bus.src_dp[SRC_ALARM*MASK_W +: MASK_W];
            sel_twk = bus.src_twk[SRC_ALARM*MASK_W +: MASK_W] & {MASK_W{blink_off_q}};
         end
         3'b100: begin
            sel_num = bus.src_num[SRC_SET*NUM_W +: NUM_W];
            sel_dp  = bus.src_dp[SRC_SET*MASK_W +: MASK_W];
            sel_twk = bus.src_twk[SRC_SET*MASK_W +: MASK_W] & {MASK_W{blink_off_q}};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      pending_d  = pending_q;
      load       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick || pending_q || (arb != grant_q)) state_d = ST_SEND;
         end
         ST_SEND: begin
            load       = 1'b1;
            pending_d  = tick;
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
         end
         ST_HOLD: begin
            if (tick) pending_d = 1'b1;
            hold_cnt_d = hold_cnt_q + HW'(1);
            if (hold_cnt_q == HOLD_LAST) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         pending_q  <= 1'b0;
         grant_q    <= '0;
         valid_q    <= 1'b0;
         num_q      <= '0;
         dp_q       <= '0;
         twk_q      <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         pending_q  <= pending_d;
         valid_q    <= load;
         if (load) begin
            grant_q <= arb;
            num_q   <= sel_num;
            dp_q    <= sel_dp;
            twk_q   <= sel_twk;
         end
      end
   end

   assign bus.grant    = grant_q;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.valid_sd = valid_q;
   assign bus.twinkle  = twk_q;
   assign bus.dp       = dp_q;
   assign bus.num6     = num_q[23:20];
   assign bus.num5     = num_q[19:16];
   assign bus.num4     = num_q[15:12];
   assign bus.num3     = num_q[11:8];
   assign bus.num2     = num_q[7:4];
   assign bus.num1     = num_q[3:0];

endmodule

// File: tb/tb_sd_sched.sv
// Randomized bench for sd_sched against a frame-level reference model.
module tb_sd_sched;

   localparam int R = 100;
   localparam int S = 20;
   localparam int B = 300;
   localparam int NCYC = 4000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sd_sched_if bus();

   sd_sched #(.REFRESH_CYC(R), .SHIFT_CYC(S), .BLINK_CYC(B)) dut (
      .sysclk (clk),
      .rst    (rst),
      .bus    (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Source stimulus
   logic [2:0]  req;
   logic [23:0] s_num [3];
   logic [5:0]  s_dp  [3];
   logic [5:0]  s_twk [3];

   // Reference model: n is the cycle index since reset; a frame occupies
   // SEND at send_at and HOLD until free_at.
   int          n, send_at, free_at;
   bit          pending;
   bit          e_valid, e_busy;
   logic [2:0]  e_grant;
   logic [23:0] e_num;
   logic [5:0]  e_dp, e_twk;

   task automatic apply();
      bus.src_req = req;
      for (int k = 0; k < 3; k++) begin
         bus.src_num[24*k +: 24] = s_num[k];
         bus.src_dp[6*k +: 6]    = s_dp[k];
         bus.src_twk[6*k +: 6]   = s_twk[k];
      end
   endtask

   function automatic int top_src(input logic [2:0] r);
      for (int k = 2; k >= 0; k--) if (r[k]) return k;
      return -1;
   endfunction

   task automatic model_reset();
      n = 0; send_at = -1; free_at = 0; pending = 0;
      e_valid = 0; e_busy = 0; e_grant = '0; e_num = '0; e_dp = '0; e_twk = '0;
   endtask

   task automatic model_step();
      bit         tick, blink_off;
      int         w;
      logic [2:0] arb;
      tick      = (n % R) == R - 1;
      blink_off = ((n / B) % 2) == 1;
      w         = top_src(req);
      arb       = (w < 0) ? 3'b000 : 3'(1 << w);
      e_valid   = 0;
      if (n == send_at) begin
         e_grant = arb;
         if (w < 0) begin
            e_num = '0; e_dp = '0; e_twk = 6'b111111;
         end else begin
            e_num = s_num[w]; e_dp = s_dp[w]; e_twk = blink_off ? s_twk[w] : 6'b0;
         end
         e_valid = 1;
         pending = tick;
      end else if (n < free_at) begin
         if (tick) pending = 1;
      end else if (tick || pending || (arb != e_grant)) begin
         send_at = n + 1;
         free_at = n + S + 2;
      end
      n++;
      e_busy = (n >= send_at) && (n < free_at);
   endtask

   task automatic compare_all();
      chk("valid_sd", 32'(bus.valid_sd), 32'(e_valid));
      chk("busy",     32'(bus.busy),     32'(e_busy));
      chk("grant",    32'(bus.grant),    32'(e_grant));
      chk("num",      32'({bus.num6, bus.num5, bus.num4, bus.num3, bus.num2, bus.num1}), 32'(e_num));
      chk("dp",       32'(bus.dp),       32'(e_dp));
      chk("twinkle",  32'(bus.twinkle),  32'(e_twk));
   endtask

   initial begin
      bit mid_rst_done;
      int k;
      mid_rst_done = 0;
      req = 3'b000;
      s_num[0] = 24'h311190; s_dp[0] = 6'b100010; s_twk[0] = 6'b000000;
      s_num[1] = 24'h070030; s_dp[1] = 6'b000100; s_twk[1] = 6'b110000;
      s_num[2] = 24'h125959; s_dp[2] = 6'b010100; s_twk[2] = 6'b000011;
      apply();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      compare_all();

      for (int c = 0; c < NCYC; c++) begin
         if (rst) model_reset();
         else     model_step();
         @(posedge clk);
         #1;
         compare_all();
         rst = 1'b0;

         if (c == 300) req = 3'b001;
         else if (c > 300) begin
            if ($urandom_range(0, 39) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) begin
               k = $urandom_range(0, 2);
               s_num[k] = 24'($urandom);
               s_dp[k]  = 6'($urandom);
               s_twk[k] = 6'($urandom);
            end
         end
         if (c > 2000 && !mid_rst_done && e_busy && !e_valid && e_grant != 3'b000) begin
            rst = 1'b1;
            req = 3'b010;
            mid_rst_done = 1;
         end
         apply();
      end

      chk("mid_reset_applied", 32'(mid_rst_done), 32'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
